// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-4 demux feeder: FSM states,
// destination channel codes and the dest -> {sel0,sel1} mapping.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEST_W = 2;

  localparam logic [DEST_W-1:0] CH_Y0 = 2'd0;
  localparam logic [DEST_W-1:0] CH_Y1 = 2'd1;
  localparam logic [DEST_W-1:0] CH_Y2 = 2'd2;
  localparam logic [DEST_W-1:0] CH_Y3 = 2'd3;

  // Bit 1 of the destination drives sel0 (demux MSB), bit 0 drives sel1.
  function automatic logic [1:0] dest_to_sel(input logic [DEST_W-1:0] dest);
    return {dest[1], dest[0]};
  endfunction

endpackage

// File: rtl/demux_1_4_serializer_piso_shreg.sv
// Parallel-in serial-out shift register: load a word, shift right, LSB is
// the serial output. Load has priority over shift; clear has priority over both.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         lsb
);

  logic [W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= din;
    end else if (shift) begin
      data_reg <= data_reg >> 1;
    end
  end

  assign lsb = data_reg[0];

endmodule

// File: rtl/demux_1_4_serializer.sv
// Serializes a parallel word LSB-first onto dout for a downstream 1-to-4 demux,
// with registered channel selects, per-bit strobe and end-of-frame pulse.
module demux_1_4_serializer
  import demux_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              sel0,
  output logic              sel1,
  output logic              dout,
  output logic              bit_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [1:0]       sel_reg;
  logic             accept;
  logic             last_bit;
  logic             gap_end;
  logic             shreg_lsb;

  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt_reg == BIT_LAST);
  assign gap_end  = (gap_cnt_reg == GAP_LAST);

  piso_shreg #(
    .W(DATA_W)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(state_reg == SHIFT),
    .din  (in_data),
    .lsb  (shreg_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      sel_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == SHIFT) begin
        bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + 1'b1;
      end
      if (state_reg == GAP) begin
        gap_cnt_reg <= gap_end ? '0 : gap_cnt_reg + 1'b1;
      end
      // Selects move only on an accept, so they stay stable for the whole frame.
      if (accept) begin
        sel_reg <= dest_to_sel(in_dest);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = (GAP_CYC > 0) ? GAP : IDLE;
      GAP:     if (gap_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_reg == IDLE) && !rst;
    bit_valid  = (state_reg == SHIFT);
    dout       = (state_reg == SHIFT) && shreg_lsb;
    frame_done = (state_reg == SHIFT) && last_bit;
    busy       = (state_reg != IDLE);
  end

  assign sel0 = sel_reg[1];
  assign sel1 = sel_reg[0];

endmodule

// File: doc/demux_1_4_serializer.md
Name: demux_1_4_serializer

Overview:
Upstream feeder for the 1-to-4 bit demux.
- Accepts a parallel word plus a 2-bit destination over a valid/ready handshake.
- Registers the destination onto sel0/sel1 and shifts the word out LSB-first on dout, one bit per clock.
- The downstream demux routes that bit stream to channel y0..y3. A per-bit strobe and an end-of-frame pulse accompany the stream.

Parameters:
DATA_W, 8, word width in bits (>=1)
GAP_CYC, 1, idle cycles inserted after each frame before the next word is accepted (>=0)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  word offered
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  word to serialize
in_dest  input  2  destination channel: {sel0,sel1} = in_dest[1:0]; 0->y0, 1->y1, 2->y2, 3->y3
sel0  output  1  demux select MSB, registered
sel1  output  1  demux select LSB, registered
dout  output  1  serial data bit to demux input i, registered
bit_valid  output  1  high in every cycle dout carries a frame bit
frame_done  output  1  one-cycle pulse coincident with the last bit of a frame
busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; sel0=sel1=dout=bit_valid=frame_done=0; shift register and counters = 0.
  - in_ready is forced to 0 while rst is high.
  - Reset mid-frame abandons the frame; all outputs are 0 after that edge.
- States:
  - IDLE: in_ready=1.
  - SHIFT: DATA_W cycles.
  - GAP: GAP_CYC cycles.
- Transitions:
  - IDLE->SHIFT on in_valid&&in_ready.
  - SHIFT->GAP after the last bit when GAP_CYC>0.
  - SHIFT->IDLE after the last bit when GAP_CYC=0.
  - GAP->IDLE when the gap counter expires.
- Accept at edge E (in_valid=1, state IDLE):
  - in_data is latched into the shift register.
  - in_dest[1] goes to sel0 and in_dest[0] to sel1, visible after E.
  - Bit k (k=0..DATA_W-1) is on dout with bit_valid=1 in cycle k after E.
  - frame_done=1 only with bit DATA_W-1.
- in_ready = (state==IDLE) && !rst; combinational from state only, with no dependency on in_valid.
- Throughput: one word per DATA_W+GAP_CYC+1 cycles (no skid, no back-to-back accept).
- Outside SHIFT: dout=0 and bit_valid=0.
- sel0/sel1 hold the last accepted destination until the next accept; they change only at an accept edge, never mid-frame.
- in_valid while busy: ignored, no state change. The source must hold data and dest stable until accepted. in_data/in_dest are don't-care when not accepted.
- Bit counter width: $clog2(DATA_W) bits, minimum 1. The gap counter is sized for GAP_CYC, minimum 1 bit.
- DATA_W=1: a single SHIFT cycle with bit_valid=1 and frame_done=1 together.
- No X on any output after the first reset edge.

Decomposition:
- Shared package demux_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - DEST_W=2;
  - channel constants CH_Y0=2'd0, CH_Y1=2'd1, CH_Y2=2'd2, CH_Y3=2'd3;
  - helper mapping dest to {sel0,sel1}.
- One natural sub-module: piso_shreg (parallel load, shift-right, LSB out, load/shift enables, synchronous clear). The FSM and counters stay in the top.
- The demux itself is not instantiated here; an integration bench connects sel0/sel1/dout to demux_1_4 inputs.

Test Plan:
1. Reset, then in_data=8'hA5, in_dest=2, single valid pulse in IDLE.
   - Required: sel0=1, sel1=0 from the next cycle.
   - dout over 8 cycles = 1,0,1,0,0,1,0,1; bit_valid high those 8 cycles.
   - frame_done on the 8th; in_ready low 9 cycles total (GAP_CYC=1), then high.
2. in_valid held high with in_data=8'h3C, in_dest=1, changed to 8'hFF, in_dest=3 while busy.
   - Required: the first frame is unaffected (dout=0,0,1,1,1,1,0,0, sel={0,1}).
   - The second word is accepted only in the first IDLE cycle.
3. GAP_CYC=0, back-to-back words 8'h01 (dest 0), 8'h80 (dest 3).
   - Required: the second accept occurs in the cycle after the first frame_done.
   - sel switches {0,0}->{1,1} only at that edge; exactly one IDLE cycle between frames.
4. rst asserted at bit 3 of a frame with in_data=8'hFF.
   - Required: the next cycle dout=0, bit_valid=0, frame_done=0, sel0=sel1=0, busy=0.
   - in_ready=1 once rst drops.
5. DATA_W=1, GAP_CYC=2, in_data=1, dest=1.
   - Required: one cycle of dout=1, bit_valid=1, frame_done=1, then 2 GAP cycles with dout=0, then in_ready=1.
6. Integration with demux_1_4, all four dests, in_data=8'h5A each.
   - Required: only the addressed y output toggles with the pattern; the other three stay 0 throughout.
